// File: rtl/csel_adder_pipe_if.sv
// -----------------------------------------------------------------------------
// csel_adder_pipe_if
//   Streaming bundle for the pipelined carry-select adder.
//   Input side : in_valid/in_ready handshake with operands a, b and carry cin.
//   Output side: out_valid/out_ready handshake with sum, cout and ovf.
//   Modports:
//     master - upstream/downstream environment (drives operands, out_ready)
//     slave  - the adder itself (drives in_ready and the result)
// -----------------------------------------------------------------------------
interface csel_adder_pipe_if #(
  parameter int WIDTH = 45
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/csel_adder_pipe.sv
// -----------------------------------------------------------------------------
// csel_adder_pipe
//   Pipelined carry-select adder: sum = a + b + cin (mod 2^WIDTH), cout = carry
//   out of bit WIDTH-1. The addition is cut into SEG-bit segments and one
//   segment is resolved per pipeline stage, so the carry path per cycle is one
//   segment adder plus a 2:1 mux. NSEG = ceil(WIDTH/SEG) stages, latency NSEG
//   cycles, one result per cycle under full valid/ready backpressure.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset (discards everything in flight)
//     bus  - csel_adder_pipe_if.slave (in_valid/in_ready/a/b/cin,
//            out_valid/out_ready/sum/cout/ovf)
//
//   Optional feature (macro CSEL_ADDER_PIPE_OVF_EN):
//     defined     - ovf is a registered signed-overflow flag aligned with sum
//     not defined - ovf is tied to 0 and no extra flop exists
// -----------------------------------------------------------------------------
module csel_adder_pipe #(
  parameter int WIDTH = 45,
  parameter int SEG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  csel_adder_pipe_if.slave  bus
);

  localparam int NSEG = (WIDTH + SEG - 1) / SEG;

  // The whole pipeline moves as one unit: it advances whenever the output slot
  // is empty or is being drained this cycle, otherwise every stage holds.
  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Stage k owns sum bits [HI-1:0] (everything resolved so far) and carries
  // the not-yet-added operand bits [WIDTH-1:HI] down the pipe, right-aligned
  // so that the next stage always finds its segment at bit 0.
  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int W  = (k == NSEG - 1) ? WIDTH - LO : SEG;
    localparam int HI = LO + W;

    logic              vld_in;
    logic              cy_in;
    logic [WIDTH-LO-1:0] a_rem;
    logic [WIDTH-LO-1:0] b_rem;
    logic [HI-1:0]     sum_d;

    logic [W:0]        seg_c0;
    logic [W:0]        seg_c1;
    logic [W:0]        seg_sel;

    logic              vld_q;
    logic              cy_q;
    logic [HI-1:0]     sum_q;

    if (k == 0) begin : g_head
      assign vld_in = bus.in_valid;
      assign cy_in  = bus.cin;
      assign a_rem  = bus.a;
      assign b_rem  = bus.b;
      assign sum_d  = seg_sel[W-1:0];
    end else begin : g_body
      assign vld_in = g_stage[k-1].vld_q;
      assign cy_in  = g_stage[k-1].cy_q;
      assign a_rem  = g_stage[k-1].g_fwd.a_q;
      assign b_rem  = g_stage[k-1].g_fwd.b_q;
      assign sum_d  = {seg_sel[W-1:0], g_stage[k-1].sum_q};
    end

    // Both carry variants are formed in parallel from the operands alone; the
    // incoming carry only drives the final select.
    assign seg_c0  = {1'b0, a_rem[W-1:0]} + {1'b0, b_rem[W-1:0]};
    assign seg_c1  = {1'b0, a_rem[W-1:0]} + {1'b0, b_rem[W-1:0]} + {{W{1'b0}}, 1'b1};
    assign seg_sel = cy_in ? seg_c1 : seg_c0;

    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its predecessor's value from before this edge, which is what
    // makes the chain a pipeline rather than a ripple through all stages.
    // NOTE: these are individual pipeline flops, not a RAM array, so they all
    // take the synchronous clear; stale partial sums never leak after reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        cy_q  <= seg_sel[W];
        sum_q <= sum_d;
      end
    end

    // Skew registers: only stages that still have operand bits to hand on.
    if (k < NSEG - 1) begin : g_fwd
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_rem[WIDTH-LO-1:W];
          b_q <= b_rem[WIDTH-LO-1:W];
        end
      end
    end
  end

  assign bus.out_valid = g_stage[NSEG-1].vld_q;
  assign bus.sum       = g_stage[NSEG-1].sum_q;
  assign bus.cout      = g_stage[NSEG-1].cy_q;

`ifdef CSEL_ADDER_PIPE_OVF_EN
  // The operand MSBs arrive at the last stage through the skew registers, so
  // the flag is computed alongside the top segment and registered with it.
  localparam int LAST_W = WIDTH - (NSEG - 1) * SEG;

  logic a_msb;
  logic b_msb;
  logic s_msb;
  logic ovf_q;

  assign a_msb = g_stage[NSEG-1].a_rem[LAST_W-1];
  assign b_msb = g_stage[NSEG-1].b_rem[LAST_W-1];
  assign s_msb = g_stage[NSEG-1].seg_sel[LAST_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= (a_msb == b_msb) && (s_msb != a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csel_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_csel_adder_pipe
//   Self-checking bench for csel_adder_pipe. Four instances (SEG = 8, 1, 5, 45
//   at WIDTH = 45) share one stimulus stream; expected results come from a
//   plain-arithmetic reference of a + b + cin and its signed interpretation.
// -----------------------------------------------------------------------------
module tb_csel_adder_pipe;

  localparam int W     = 45;
  localparam int NINST = 4;
  localparam int NRAND = 200;

  typedef struct packed {
    logic         ovf;
    logic         cout;
    logic [W-1:0] sum;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         cin;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;

  int n_checks = 0;
  int n_pass   = 0;

  // Latency of each instance in the order seg8, seg1, seg5, seg45.
  int lat [NINST] = '{6, 45, 9, 1};

  always #5 clk = ~clk;

  csel_adder_pipe_if #(.WIDTH(W)) if8  ();
  csel_adder_pipe_if #(.WIDTH(W)) if1  ();
  csel_adder_pipe_if #(.WIDTH(W)) if5  ();
  csel_adder_pipe_if #(.WIDTH(W)) if45 ();

  csel_adder_pipe #(.WIDTH(W), .SEG(8))  u_seg8  (.clk(clk), .rst(rst), .bus(if8));
  csel_adder_pipe #(.WIDTH(W), .SEG(1))  u_seg1  (.clk(clk), .rst(rst), .bus(if1));
  csel_adder_pipe #(.WIDTH(W), .SEG(5))  u_seg5  (.clk(clk), .rst(rst), .bus(if5));
  csel_adder_pipe #(.WIDTH(W), .SEG(45)) u_seg45 (.clk(clk), .rst(rst), .bus(if45));

  assign if8.in_valid  = in_valid;  assign if8.a  = a;  assign if8.b  = b;
  assign if8.cin       = cin;       assign if8.out_ready  = out_ready;
  assign if1.in_valid  = in_valid;  assign if1.a  = a;  assign if1.b  = b;
  assign if1.cin       = cin;       assign if1.out_ready  = out_ready;
  assign if5.in_valid  = in_valid;  assign if5.a  = a;  assign if5.b  = b;
  assign if5.cin       = cin;       assign if5.out_ready  = out_ready;
  assign if45.in_valid = in_valid;  assign if45.a = a;  assign if45.b = b;
  assign if45.cin      = cin;       assign if45.out_ready = out_ready;

  logic [NINST-1:0]        obs_valid;
  logic [NINST-1:0]        obs_ready;
  logic [NINST-1:0]        obs_cout;
  logic [NINST-1:0]        obs_ovf;
  logic [NINST-1:0][W-1:0] obs_sum;

  assign obs_valid[0] = if8.out_valid;  assign obs_valid[1] = if1.out_valid;
  assign obs_valid[2] = if5.out_valid;  assign obs_valid[3] = if45.out_valid;
  assign obs_ready[0] = if8.in_ready;   assign obs_ready[1] = if1.in_ready;
  assign obs_ready[2] = if5.in_ready;   assign obs_ready[3] = if45.in_ready;
  assign obs_cout[0]  = if8.cout;       assign obs_cout[1]  = if1.cout;
  assign obs_cout[2]  = if5.cout;       assign obs_cout[3]  = if45.cout;
  assign obs_ovf[0]   = if8.ovf;        assign obs_ovf[1]   = if1.ovf;
  assign obs_ovf[2]   = if5.ovf;        assign obs_ovf[3]   = if45.ovf;
  assign obs_sum[0]   = if8.sum;        assign obs_sum[1]   = if1.sum;
  assign obs_sum[2]   = if5.sum;        assign obs_sum[3]   = if45.sum;

  // Reference: unsigned sum and carry from 64-bit arithmetic; signed overflow
  // from the two's-complement value of the operands falling outside the range.
  function automatic res_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    res_t            r;
    longint unsigned total;
`ifdef CSEL_ADDER_PIPE_OVF_EN
    longint lim;
    longint sx;
    longint sy;
    longint st;
`endif
    total  = 64'(x) + 64'(y) + 64'(c);
    r.sum  = total[W-1:0];
    r.cout = total[W];
`ifdef CSEL_ADDER_PIPE_OVF_EN
    lim   = longint'(1) <<< (W - 1);
    sx    = x[W-1] ? longint'(x) - 2 * lim : longint'(x);
    sy    = y[W-1] ? longint'(y) - 2 * lim : longint'(y);
    st    = sx + sy + longint'(c);
    r.ovf = (st >= lim) || (st < -lim);
`else
    r.ovf = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    v = W'({$urandom(), $urandom()});
    case ($urandom_range(0, 15))
      0:       v = '1;
      1:       v = '0;
      2:       v = {1'b0, {(W-1){1'b1}}};
      default: ;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = c;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < NINST; i++) begin
      n_checks++;
      if ({obs_ready[i], obs_valid[i], obs_cout[i], obs_ovf[i], obs_sum[i]} !==
          {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
        $display("FAIL reset_state inst=%0d got rdy=%b vld=%b cout=%b ovf=%b sum=%h exp rdy=1 vld=0 cout=0 ovf=0 sum=0",
                 i, obs_ready[i], obs_valid[i], obs_cout[i], obs_ovf[i], obs_sum[i]);
      end else n_pass++;
    end
    rst = 1'b0;
  endtask

  // All-ones plus one: the carry has to cross every segment boundary.
  task automatic test_ripple();
    logic [W-1:0] ones;
    res_t         e;
    ones = '1;
    do_reset();
    e = ref_add(ones, 1, 1'b0);
    drive(1'b1, ones, 1, 1'b0);
    for (int s = 0; s <= 6; s++) begin
      tick();
      drive(1'b0, '0, '0, 1'b0);
      n_checks++;
      if (obs_valid[0] !== (s == 5)) begin
        $display("FAIL ripple_latency cycle=%0d got vld=%b exp vld=%b", s + 1, obs_valid[0], s == 5);
      end else n_pass++;
      if (s == 5) begin
        n_checks++;
        if ({obs_cout[0], obs_sum[0]} !== {e.cout, e.sum}) begin
          $display("FAIL ripple_value got cout=%b sum=%h exp cout=%b sum=%h",
                   obs_cout[0], obs_sum[0], e.cout, e.sum);
        end else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e [2];
    do_reset();
    e[0] = ref_add(45'h123, 45'h456, 1'b1);
    e[1] = ref_add(45'h0FF, 45'h001, 1'b0);
    drive(1'b1, 45'h123, 45'h456, 1'b1);
    tick();
    drive(1'b1, 45'h0FF, 45'h001, 1'b0);
    for (int s = 1; s <= 7; s++) begin
      tick();
      drive(1'b0, '0, '0, 1'b0);
      n_checks++;
      if (s == 5 || s == 6) begin
        if ({obs_valid[0], obs_cout[0], obs_sum[0]} !== {1'b1, e[s-5].cout, e[s-5].sum}) begin
          $display("FAIL back_to_back_%0d got vld=%b cout=%b sum=%h exp vld=1 cout=%b sum=%h",
                   s - 5, obs_valid[0], obs_cout[0], obs_sum[0], e[s-5].cout, e[s-5].sum);
        end else n_pass++;
      end else begin
        if (obs_valid[0] !== 1'b0) begin
          $display("FAIL back_to_back_gap cycle=%0d got vld=%b exp vld=0", s, obs_valid[0]);
        end else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    res_t         q[$];
    res_t         e;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c;
    int           got;
    got = 0;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      x = rand_op();
      y = rand_op();
      c = 1'($urandom_range(0, 1));
      q.push_back(ref_add(x, y, c));
      drive(1'b1, x, y, c);
      tick();
    end
    // Keep offering an operand while stalled; it must not be taken.
    out_ready = 1'b0;
    drive(1'b1, rand_op(), rand_op(), 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({obs_ready[0], obs_valid[0], obs_sum[0]} !== {1'b0, 1'b1, q[0].sum}) begin
        $display("FAIL stall_hold cycle=%0d got rdy=%b vld=%b sum=%h exp rdy=0 vld=1 sum=%h",
                 k, obs_ready[0], obs_valid[0], obs_sum[0], q[0].sum);
      end else n_pass++;
    end
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (obs_valid[0]) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL drain_extra got vld=1 sum=%h exp no further result", obs_sum[0]);
        end else begin
          e = q.pop_front();
          got++;
          if ({obs_cout[0], obs_sum[0]} !== {e.cout, e.sum}) begin
            $display("FAIL drain_order idx=%0d got cout=%b sum=%h exp cout=%b sum=%h",
                     got - 1, obs_cout[0], obs_sum[0], e.cout, e.sum);
          end else n_pass++;
        end
      end
      tick();
    end
    n_checks++;
    if (got !== 6 || q.size() != 0) begin
      $display("FAIL drain_count got %0d results exp 6", got);
    end else n_pass++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < NINST; i++) begin
        n_checks++;
        if ({obs_valid[i], obs_sum[i]} !== {1'b0, {W{1'b0}}}) begin
          $display("FAIL reset_flush cycle=%0d inst=%0d got vld=%b sum=%h exp vld=0 sum=0",
                   s, i, obs_valid[i], obs_sum[i]);
        end else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_ovf();
    res_t         e [2];
    logic [W-1:0] op [2];
    op[0] = 45'h0FFF_FFFF_FFFF;
    op[1] = 45'h1FFF_FFFF_FFFF;
    do_reset();
    e[0] = ref_add(op[0], 1, 1'b0);
    e[1] = ref_add(op[1], 1, 1'b0);
    drive(1'b1, op[0], 1, 1'b0);
    tick();
    drive(1'b1, op[1], 1, 1'b0);
    for (int s = 1; s <= 6; s++) begin
      tick();
      drive(1'b0, '0, '0, 1'b0);
      if (s >= 5) begin
        n_checks++;
        if ({obs_valid[0], obs_ovf[0], obs_cout[0], obs_sum[0]} !==
            {1'b1, e[s-5].ovf, e[s-5].cout, e[s-5].sum}) begin
          $display("FAIL ovf_%0d got vld=%b ovf=%b cout=%b sum=%h exp vld=1 ovf=%b cout=%b sum=%h",
                   s - 5, obs_valid[0], obs_ovf[0], obs_cout[0], obs_sum[0],
                   e[s-5].ovf, e[s-5].cout, e[s-5].sum);
        end else n_pass++;
      end
    end
  endtask

  // Random stream with random bubbles, every instance checked against its own
  // latency: slot n of the input stream must show up exactly lat-1 edges later.
  task automatic test_sweep();
    bit           vseq[$];
    res_t         eseq[$];
    logic [W-1:0] aseq[$];
    logic [W-1:0] bseq[$];
    bit           cseq[$];
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c;
    bit           v;
    int           nv;
    int           j;
    nv = 0;
    while (nv < NRAND) begin
      v = ($urandom_range(0, 7) != 0);
      x = rand_op();
      y = rand_op();
      c = 1'($urandom_range(0, 1));
      vseq.push_back(v);
      aseq.push_back(x);
      bseq.push_back(y);
      cseq.push_back(c);
      eseq.push_back(ref_add(x, y, c));
      if (v) nv++;
    end
    do_reset();
    for (int n = 0; n < vseq.size() + 46; n++) begin
      if (n < vseq.size()) drive(vseq[n], aseq[n], bseq[n], cseq[n]);
      else drive(1'b0, '0, '0, 1'b0);
      tick();
      for (int i = 0; i < NINST; i++) begin
        j = n - (lat[i] - 1);
        n_checks++;
        if (j >= 0 && j < vseq.size() && vseq[j]) begin
          if ({obs_valid[i], obs_cout[i], obs_ovf[i], obs_sum[i]} !==
              {1'b1, eseq[j].cout, eseq[j].ovf, eseq[j].sum}) begin
            $display("FAIL sweep inst=%0d slot=%0d got vld=%b cout=%b ovf=%b sum=%h exp vld=1 cout=%b ovf=%b sum=%h",
                     i, j, obs_valid[i], obs_cout[i], obs_ovf[i], obs_sum[i],
                     eseq[j].cout, eseq[j].ovf, eseq[j].sum);
          end else n_pass++;
        end else begin
          if (obs_valid[i] !== 1'b0) begin
            $display("FAIL sweep_bubble inst=%0d cycle=%0d got vld=%b exp vld=0", i, n, obs_valid[i]);
          end else n_pass++;
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    test_reset();
    test_ripple();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_ovf();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no end of test exp finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
